// File: rtl/alu_multicycle_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_multicycle_unit : ALUOp/Func decode with single-cycle logic/add/sub/slt
// and iterative unsigned mult/div/mod. Optional ovf port: ALU_MULTICYCLE_OVF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_multicycle_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_zero
`ifdef ALU_MULTICYCLE_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
      OP_SLT = 4'd5, OP_MUL = 4'd6, OP_DIV = 4'd7, OP_MOD = 4'd8
   } op_t;

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state, w_next_state;
   op_t              w_op, r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo, r_b;
   logic [WIDTH-1:0] r_res_lo, r_res_hi;
   logic             r_done, r_div_zero;

   logic             w_accept, w_iter, w_div0, w_go_run, w_last;
   logic [WIDTH-1:0] w_sum, w_dif, w_s_lo, w_s_hi;
   logic [WIDTH:0]   w_madd, w_shift;
   logic [WIDTH-1:0] w_rsub;
   logic             w_ge;
   logic [WIDTH-1:0] w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;

   always_comb begin
      w_op = OP_ADD;
      if (alu_op == 4'd8) begin
         case (func)
            6'h02:   w_op = OP_SUB;
            6'h08:   w_op = OP_MUL;
            6'h1A:   w_op = OP_DIV;
            6'h04:   w_op = OP_AND;
            6'h05:   w_op = OP_OR;
            6'h06:   w_op = OP_XOR;
            6'h2A:   w_op = OP_SLT;
            6'h07:   w_op = OP_MOD;
            default: w_op = OP_ADD;
         endcase
      end else begin
         case (alu_op)
            4'd1:    w_op = OP_SUB;
            4'd2:    w_op = OP_AND;
            4'd3:    w_op = OP_OR;
            4'd4:    w_op = OP_XOR;
            4'd5:    w_op = OP_SLT;
            default: w_op = OP_ADD;
         endcase
      end
   end

   assign w_accept = start && (r_state != S_RUN);
   assign w_iter   = (w_op == OP_MUL) || (w_op == OP_DIV) || (w_op == OP_MOD);
   assign w_div0   = ((w_op == OP_DIV) || (w_op == OP_MOD)) && (op_b == '0);
   assign w_go_run = w_accept && w_iter && !w_div0;
   assign w_last   = (r_cnt == c_LAST);
   assign w_sum    = op_a + op_b;
   assign w_dif    = op_a - op_b;

   // Divide-by-zero results are produced here; mult never takes this path.
   always_comb begin
      w_s_lo = '0;
      w_s_hi = '0;
      case (w_op)
         OP_SUB:  w_s_lo = w_dif;
         OP_AND:  w_s_lo = op_a & op_b;
         OP_OR:   w_s_lo = op_a | op_b;
         OP_XOR:  w_s_lo = op_a ^ op_b;
         OP_SLT:  w_s_lo = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_MUL:  w_s_lo = '0;
         OP_DIV:  begin w_s_lo = '1; w_s_hi = op_a; end
         OP_MOD:  w_s_lo = op_a;
         default: w_s_lo = w_sum;
      endcase
   end

   // Iteration datapath: {r_hi,r_lo} is the product/multiplier pair for mult,
   // and the partial remainder/shifting quotient pair for div/mod.
   assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   assign w_rsub  = w_shift[WIDTH-1:0] - r_b;

   always_comb begin
      w_step_hi = w_ge ? w_rsub : w_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_ge};
      w_fin_hi  = w_step_hi;
      w_fin_lo  = w_step_lo;
      if (r_op == OP_MUL) begin
         w_step_hi = w_madd[WIDTH:1];
         w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
         w_fin_hi  = w_step_hi;
         w_fin_lo  = w_step_lo;
      end else if (r_op == OP_MOD) begin
         w_fin_hi  = '0;
         w_fin_lo  = w_step_hi;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_FIN: w_next_state = w_go_run ? S_RUN : S_IDLE;
         S_RUN:         if (w_last) w_next_state = S_FIN;
         default:       w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= OP_ADD;
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_b        <= '0;
         r_res_lo   <= '0;
         r_res_hi   <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= 1'b0;
         if (w_accept) begin
            r_div_zero <= w_div0;
            if (w_go_run) begin
               r_op  <= w_op;
               r_cnt <= '0;
               r_hi  <= '0;
               r_lo  <= (w_op == OP_MUL) ? op_b : op_a;
               r_b   <= (w_op == OP_MUL) ? op_a : op_b;
            end else begin
               r_done   <= 1'b1;
               r_res_lo <= w_s_lo;
               r_res_hi <= w_s_hi;
            end
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            if (w_last) begin
               r_done   <= 1'b1;
               r_res_lo <= w_fin_lo;
               r_res_hi <= w_fin_hi;
            end
         end
      end
   end

   assign busy      = (r_state == S_RUN);
   assign done      = r_done;
   assign result_lo = r_res_lo;
   assign result_hi = r_res_hi;
   assign div_zero  = r_div_zero;

`ifdef ALU_MULTICYCLE_OVF_EN
   logic r_ovf, w_ovf;

   always_comb begin
      w_ovf = 1'b0;
      if (w_op == OP_ADD)
         w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      else if (w_op == OP_SUB)
         w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_dif[WIDTH-1] != op_a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst)           r_ovf <= 1'b0;
      else if (w_accept) r_ovf <= w_ovf;
   end

   assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/alu_multicycle_unit.md
Name: alu_multicycle_unit

Overview:
- Parametrised successor to the single-cycle ALU control/decode path.
- Decodes the existing 4-bit ALUOp / 6-bit Func encoding internally and executes the selected operation on WIDTH-bit operands.
- Logic ops, add/sub and slt complete in one cycle; mult, div and mod run as iterative multi-cycle engines behind a start/busy/done handshake.
- Sits between the register-file read stage and write-back; the control unit stalls on busy.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when busy=0
alu_op  input  4  ALUOp code
func  input  6  R-type function field, used when alu_op=8
op_a  input  WIDTH  operand A / dividend / multiplicand
op_b  input  WIDTH  operand B / divisor / multiplier
busy  output  1  high while an accepted operation is in progress
done  output  1  one-cycle pulse: result_lo/result_hi valid
result_lo  output  WIDTH  primary result: low product, quotient or remainder
result_hi  output  WIDTH  mult: high product; div: remainder; otherwise 0
div_zero  output  1  sticky per-op flag: last div/mod had op_b=0

Behaviour:
- Reset (synchronous, rst=1 at rising edge): state=IDLE; busy=0, done=0, result_lo=0, result_hi=0, div_zero=0; any in-flight operation is discarded.
- Decode:
  - alu_op 0..5 select add, sub, and, or, xor, slt respectively.
  - alu_op=8 selects by func: 0 add, 2 sub, 8 mult, 0x1A div, 4 and, 5 or, 6 xor, 0x2A slt, 7 mod.
  - Any other alu_op or func decodes to add.
- Operand capture: op_a, op_b and the decoded op are latched at the accepting edge; later input changes do not affect the running op.
- Arithmetic rules:
  - add/sub wrap modulo 2**WIDTH.
  - slt is a signed compare; result_lo = 1 or 0.
  - mult, div and mod are unsigned.
  - mult yields a full 2*WIDTH product {result_hi, result_lo}.
  - div: result_lo = quotient, result_hi = remainder.
  - mod: result_lo = remainder, result_hi = 0.
- State machine (IDLE, RUN, FIN):
  - IDLE & start & single-cycle op: result registered at that edge; done=1 for the next cycle; busy stays 0; latency 1.
  - IDLE & start & mult/div/mod with op_b!=0: -> RUN, busy=1, counter=0.
  - RUN: one shift-add (mult) or restoring-subtract (div/mod) step per cycle; after WIDTH steps -> FIN.
  - FIN: results registered, done=1 for one cycle, busy=0 -> IDLE.
  - Start-to-done latency for iterative ops: WIDTH+1 cycles.
- Divide by zero: div/mod with op_b=0 completes in 1 cycle like a single-cycle op.
  - div: result_lo = all ones, result_hi = op_a. mod: result_lo = op_a.
  - div_zero=1 until the next accepted start, which clears it.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done=1 is accepted, allowing back-to-back ops.
- result_lo and result_hi hold their values between done pulses.
- rst asserted mid-RUN returns to IDLE next edge with outputs zeroed; no done pulse.

Optional Feature:
- Macro: ALU_MULTICYCLE_OVF_EN.
- When defined: adds output port ovf (1 bit).
  - Set to 1 with done when add/sub signed overflow occurs (operand signs equal and result sign differs, for sub after negating op_b).
  - ovf is 0 for every other op; reset value 0.
- When undefined: port absent and no overflow logic.

Test Plan:
- WIDTH=32, alu_op=0, op_a=5, op_b=7, start -> one cycle later done=1, result_lo=12, result_hi=0, busy never 1.
- alu_op=8, func=8, op_a=0xFFFFFFFF, op_b=2 -> busy for 32 cycles; done at start+33; result_hi=1, result_lo=0xFFFFFFFE.
- alu_op=8, func=0x1A, op_a=100, op_b=7 -> done at start+33, result_lo=14, result_hi=2; with func=7 -> result_lo=2, result_hi=0.
- func=0x1A, op_a=9, op_b=0 -> done next cycle, result_lo=0xFFFFFFFF, result_hi=9, div_zero=1; next add start -> div_zero=0.
- alu_op=5, op_a=0xFFFFFFFF, op_b=1 -> result_lo=1 (signed −1<1). Issue a mult, then start again at cycle 10 -> ignored; assert rst at cycle 15 -> all outputs 0, no done.
- With ALU_MULTICYCLE_OVF_EN: alu_op=0, op_a=0x7FFFFFFF, op_b=1 -> result_lo=0x80000000, ovf=1; alu_op=1, op_a=0x80000000, op_b=1 -> ovf=1.
